// File: rtl/uart_tx_8n1_if.sv
// Byte handshake between the hex-dump reader (master) and the UART transmitter (slave).
interface uart_tx_8n1_if;
  logic       uart_send;
  logic [7:0] uart_data;
  logic       uart_ready;

  modport master (output uart_send, output uart_data, input uart_ready);
  modport slave  (input uart_send, input uart_data, output uart_ready);
endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: accepts one byte per send pulse while ready, shifts it out LSB first.
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_8n1_if.slave  bus,
  output logic          tx,
  output logic          busy
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_baud,  w_baud;
  logic [2:0]    r_bit,   w_bit;
  logic [7:0]    r_shift, w_shift;
  logic          r_tx,    w_tx;
  logic          r_ready, w_ready;
  logic          r_busy,  w_busy;
  logic          w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_tx    <= w_tx;
      r_ready <= w_ready;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_baud  = r_baud;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_tx    = r_tx;
    w_ready = r_ready;
    w_busy  = r_busy;
    case (r_state)
      IDLE: begin
        w_tx = 1'b1;
        // ready is the registered value, so a send coinciding with ready's return is not taken
        if (bus.uart_send && r_ready) begin
          w_shift = bus.uart_data;
          w_tx    = 1'b0;
          w_ready = 1'b0;
          w_busy  = 1'b1;
          w_baud  = '0;
          w_bit   = '0;
          w_state = START;
        end
      end
      START: begin
        w_baud = w_bit_end ? '0 : r_baud + 1'b1;
        if (w_bit_end) begin
          w_tx    = r_shift[0];
          w_bit   = '0;
          w_state = DATA;
        end
      end
      DATA: begin
        w_baud = w_bit_end ? '0 : r_baud + 1'b1;
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            w_tx    = 1'b1;
            w_bit   = '0;
            w_state = STOP;
          end else begin
            w_shift = {1'b0, r_shift[7:1]};
            w_tx    = r_shift[1];
            w_bit   = r_bit + 3'd1;
          end
        end
      end
      STOP: begin
        w_baud = w_bit_end ? '0 : r_baud + 1'b1;
        // bit counter is reused to count stop bits
        if (w_bit_end) begin
          if (r_bit == STOP_LAST) begin
            w_ready = 1'b1;
            w_busy  = 1'b0;
            w_bit   = '0;
            w_state = IDLE;
          end else begin
            w_bit = r_bit + 3'd1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign tx             = r_tx;
  assign busy           = r_busy;
  assign bus.uart_ready = r_ready;

endmodule
